// File: rtl/reg_d_e.sv
// ---------------------------------------------------------------------------
// reg_d_e : Decode -> Execute pipeline register.
//   Captures the bypassed decode operands, PC, instruction, immediate,
//   register indices and control bundle, and presents them to execute one
//   cycle later.
//   Per-cycle priority with rst_n high: flush > stall > load.
//   A slot loaded with D_valid=0 has its control bundle and rd cleared, so
//   it can never write the register file, touch memory or branch.
//   Optional feature macro: REG_D_E_PERF_EN adds saturating stall/bubble
//   counters (perf_stall_cnt, perf_bubble_cnt).
// ---------------------------------------------------------------------------
module reg_d_e #(
   parameter int          CTRL_W   = 12,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              D_valid,
   input  logic [31:0]       D_pc,
   input  logic [31:0]       D_inst,
   input  logic [31:0]       mux2_rs1_data_out,
   input  logic [31:0]       mux2_rs2_data_out,
   input  logic [31:0]       D_imm,
   input  logic [4:0]        D_rs1,
   input  logic [4:0]        D_rs2,
   input  logic [4:0]        D_rd,
   input  logic [CTRL_W-1:0] D_ctrl,
   output logic              E_valid,
   output logic [31:0]       E_pc,
   output logic [31:0]       E_inst,
   output logic [31:0]       E_rs1_data,
   output logic [31:0]       E_rs2_data,
   output logic [31:0]       E_imm,
   output logic [4:0]        E_rs1,
   output logic [4:0]        E_rs2,
   output logic [4:0]        E_rd,
   output logic [CTRL_W-1:0] E_ctrl
`ifdef REG_D_E_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_bubble_cnt
`endif
);

   logic              valid_q,    valid_d;
   logic [31:0]       pc_q,       pc_d;
   logic [31:0]       inst_q,     inst_d;
   logic [31:0]       rs1_data_q, rs1_data_d;
   logic [31:0]       rs2_data_q, rs2_data_d;
   logic [31:0]       imm_q,      imm_d;
   logic [4:0]        rs1_q,      rs1_d;
   logic [4:0]        rs2_q,      rs2_d;
   logic [4:0]        rd_q,       rd_d;
   logic [CTRL_W-1:0] ctrl_q,     ctrl_d;

   // Next slot contents: hold by default, bubble on flush, load otherwise.
   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      ctrl_d     = ctrl_q;
      if (flush) begin
         // Bubble wins even over stall so a squashed instruction never lingers.
         valid_d    = 1'b0;
         pc_d       = '0;
         inst_d     = NOP_INST;
         rs1_data_d = '0;
         rs2_data_d = '0;
         imm_d      = '0;
         rs1_d      = '0;
         rs2_d      = '0;
         rd_d       = '0;
         ctrl_d     = '0;
      end else if (!stall) begin
         valid_d    = D_valid;
         pc_d       = D_pc;
         inst_d     = D_inst;
         rs1_data_d = mux2_rs1_data_out;
         rs2_data_d = mux2_rs2_data_out;
         imm_d      = D_imm;
         rs1_d      = D_rs1;
         rs2_d      = D_rs2;
         rd_d       = D_valid ? D_rd   : 5'd0;
         ctrl_d     = D_valid ? D_ctrl : '0;
      end
   end

   // Slot register; reset overrides stall and flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         inst_q     <= NOP_INST;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         ctrl_q     <= '0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         ctrl_q     <= ctrl_d;
      end
   end

   assign E_valid    = valid_q;
   assign E_pc       = pc_q;
   assign E_inst     = inst_q;
   assign E_rs1_data = rs1_data_q;
   assign E_rs2_data = rs2_data_q;
   assign E_imm      = imm_q;
   assign E_rs1      = rs1_q;
   assign E_rs2      = rs2_q;
   assign E_rd       = rd_q;
   assign E_ctrl     = ctrl_q;

`ifdef REG_D_E_PERF_EN
   logic [31:0] stall_cnt_q,  stall_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic        stall_evt;
   logic        bubble_evt;

   // Saturating event counters; a bubble is a flush or a load of an invalid slot.
   always_comb begin
      stall_evt    = stall & ~flush;
      bubble_evt   = flush | (~stall & ~D_valid);
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (bubble_evt && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign perf_stall_cnt  = stall_cnt_q;
   assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_reg_d_e.sv
// ---------------------------------------------------------------------------
// tb_reg_d_e : self-checking bench for reg_d_e.
//   Directed steps followed by a randomized phase; every cycle the DUT is
//   compared against a slot model built from the register's update rules.
//   Counter checks are compiled in when REG_D_E_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_reg_d_e;

  localparam int          CTRL_W   = 12;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, stall, flush, D_valid;
  logic [31:0]       D_pc, D_inst, rs1_in, rs2_in, D_imm;
  logic [4:0]        D_rs1, D_rs2, D_rd;
  logic [CTRL_W-1:0] D_ctrl;
  logic              E_valid;
  logic [31:0]       E_pc, E_inst, E_rs1_data, E_rs2_data, E_imm;
  logic [4:0]        E_rs1, E_rs2, E_rd;
  logic [CTRL_W-1:0] E_ctrl;
`ifdef REG_D_E_PERF_EN
  logic [31:0]       perf_stall_cnt, perf_bubble_cnt;
`endif

  reg_d_e #(.CTRL_W(CTRL_W), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .D_valid(D_valid),
    .D_pc(D_pc), .D_inst(D_inst), .mux2_rs1_data_out(rs1_in),
    .mux2_rs2_data_out(rs2_in), .D_imm(D_imm), .D_rs1(D_rs1), .D_rs2(D_rs2),
    .D_rd(D_rd), .D_ctrl(D_ctrl), .E_valid(E_valid), .E_pc(E_pc),
    .E_inst(E_inst), .E_rs1_data(E_rs1_data), .E_rs2_data(E_rs2_data),
    .E_imm(E_imm), .E_rs1(E_rs1), .E_rs2(E_rs2), .E_rd(E_rd), .E_ctrl(E_ctrl)
`ifdef REG_D_E_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic              valid;
    logic [31:0]       pc, inst, rs1_data, rs2_data, imm;
    logic [4:0]        rs1, rs2, rd;
    logic [CTRL_W-1:0] ctrl;
  } slot_t;

  slot_t       m;
  longint      m_stall_cnt, m_bubble_cnt;
  int          errors = 0;
  int          checks = 0;

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    slot_t bubble;
    bubble = '{valid: 1'b0, pc: 0, inst: NOP_INST, rs1_data: 0, rs2_data: 0,
               imm: 0, rs1: 0, rs2: 0, rd: 0, ctrl: 0};
    if (!rst_n) begin
      m = bubble;
      m_stall_cnt  = 0;
      m_bubble_cnt = 0;
    end else if (flush) begin
      m = bubble;
      if (m_bubble_cnt < 64'hFFFF_FFFF) m_bubble_cnt++;
    end else if (stall) begin
      if (m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
    end else begin
      m.valid    = D_valid;
      m.pc       = D_pc;
      m.inst     = D_inst;
      m.rs1_data = rs1_in;
      m.rs2_data = rs2_in;
      m.imm      = D_imm;
      m.rs1      = D_rs1;
      m.rs2      = D_rs2;
      // An invalid slot must be side-effect free.
      m.rd       = D_valid ? D_rd : 5'd0;
      m.ctrl     = D_valid ? D_ctrl : '0;
      if (!D_valid && m_bubble_cnt < 64'hFFFF_FFFF) m_bubble_cnt++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string t);
    check({t, ".valid"},    32'(E_valid),    32'(m.valid));
    check({t, ".pc"},       E_pc,            m.pc);
    check({t, ".inst"},     E_inst,          m.inst);
    check({t, ".rs1_data"}, E_rs1_data,      m.rs1_data);
    check({t, ".rs2_data"}, E_rs2_data,      m.rs2_data);
    check({t, ".imm"},      E_imm,           m.imm);
    check({t, ".rs1"},      32'(E_rs1),      32'(m.rs1));
    check({t, ".rs2"},      32'(E_rs2),      32'(m.rs2));
    check({t, ".rd"},       32'(E_rd),       32'(m.rd));
    check({t, ".ctrl"},     32'(E_ctrl),     32'(m.ctrl));
`ifdef REG_D_E_PERF_EN
    check({t, ".stall_cnt"},  perf_stall_cnt,  m_stall_cnt[31:0]);
    check({t, ".bubble_cnt"}, perf_bubble_cnt, m_bubble_cnt[31:0]);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_d();
    D_valid = 1'($urandom_range(0, 3) != 0);
    D_pc    = $urandom;
    D_inst  = $urandom;
    rs1_in  = $urandom;
    rs2_in  = $urandom;
    D_imm   = $urandom;
    D_rs1   = 5'($urandom);
    D_rs2   = 5'($urandom);
    D_rd    = 5'($urandom);
    D_ctrl  = CTRL_W'($urandom);
  endtask

  // One clock: model consumes the applied inputs, DUT is sampled 1ns after the edge.
  task automatic tick(input string t);
    model_step();
    @(posedge clk);
    #1;
    check_all(t);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    m_stall_cnt = 0; m_bubble_cnt = 0;
    rand_d();
    #1;

    // 1. reset held two cycles with random decode inputs
    for (int i = 0; i < 2; i++) begin
      rand_d();
      tick("reset");
    end
    check("reset.inst_const", E_inst, 32'h0000_0013);
    check("reset.valid_const", 32'(E_valid), 32'd0);

    // Reset released while stall=1: first active cycle holds reset values
    rst_n = 1'b1; stall = 1'b1;
    rand_d();
    tick("rst_stall");
    check("rst_stall.inst_const", E_inst, 32'h0000_0013);
    check("rst_stall.pc_const", E_pc, 32'd0);

    // 2. load a valid instruction
    stall = 1'b0;
    rand_d();
    D_valid = 1'b1; D_pc = 32'h100; rs1_in = 32'hDEAD_BEEF; rs2_in = 32'h1234_5678;
    tick("load");
    check("load.pc_const", E_pc, 32'h100);
    check("load.rs1_const", E_rs1_data, 32'hDEAD_BEEF);
    check("load.rs2_const", E_rs2_data, 32'h1234_5678);

    // 3. stall three cycles while decode changes, then release
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      tick("stall");
      check("stall.pc_const", E_pc, 32'h100);
    end
    stall = 1'b0;
    rand_d();
    D_pc = 32'h204;
    tick("unstall");
    check("unstall.pc_const", E_pc, 32'h204);

    // 4. flush together with stall over a valid slot
    rand_d();
    D_valid = 1'b1; D_ctrl = '1;
    tick("pre_flush");
    stall = 1'b1; flush = 1'b1;
    rand_d();
    tick("flush_stall");
    check("flush.valid_const", 32'(E_valid), 32'd0);
    check("flush.inst_const", E_inst, 32'h0000_0013);
    check("flush.ctrl_const", 32'(E_ctrl), 32'd0);
    stall = 1'b0; flush = 1'b0;

    // 5. invalid slot loads with ctrl and rd suppressed
    rand_d();
    D_valid = 1'b0; D_ctrl = '1; D_rd = 5'd5; D_pc = 32'h300;
    tick("invalid");
    check("invalid.ctrl_const", 32'(E_ctrl), 32'd0);
    check("invalid.rd_const", 32'(E_rd), 32'd0);
    check("invalid.pc_const", E_pc, 32'h300);

`ifdef REG_D_E_PERF_EN
    // 6. counters: 4 stalls, 2 flushes, then reset
    rst_n = 1'b0;
    tick("perf_rst");
    rst_n = 1'b1; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_d();
      tick("perf_stall");
    end
    stall = 1'b0; flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_d();
      tick("perf_flush");
    end
    flush = 1'b0;
    check("perf.stall_const", perf_stall_cnt, 32'd4);
    check("perf.bubble_const", perf_bubble_cnt, 32'd2);
    rst_n = 1'b0;
    tick("perf_clear");
    check("perf.stall_zero", perf_stall_cnt, 32'd0);
    check("perf.bubble_zero", perf_bubble_cnt, 32'd0);
    rst_n = 1'b1;
`endif

    // Randomized phase: mixed stall/flush/valid with occasional reset
    for (int i = 0; i < 300; i++) begin
      rand_d();
      stall = 1'($urandom_range(0, 3) == 0);
      flush = 1'($urandom_range(0, 7) == 0);
      rst_n = 1'($urandom_range(0, 49) != 0);
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
